controlador_linhas_matriz: RTL and testbench

Row-side driver for the 7x5 LED matrix: it holds one 5-bit row pattern per column and, each clock, presents the pattern of the column that the 7-bit rotating column register currently selects. It is the consumer of the column ring. In load mode (ch1,ch0 = 00) it accepts pattern writes and blanks the rows. In scan mode (any other chave value) it follows the column ring, flags illegal column codes and pulses once per completed frame.

---
 rtl/controlador_linhas_matriz_pkg.sv | 16 +
 rtl/controlador_linhas_matriz_if.sv | 24 ++
 rtl/controlador_linhas_matriz_codificador.sv | 26 ++
 rtl/controlador_linhas_matriz.sv | 107 ++++++++++
 tb/tb_controlador_linhas_matriz.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/controlador_linhas_matriz_pkg.sv
// Shared constants and state encoding for the LED matrix row driver.
package pkg_matriz;

  localparam int NUM_COLUNAS = 7;
  localparam int NUM_LINHAS  = 5;

  typedef enum logic [1:0] {
    CARGA = 2'b00,
    VARRE = 2'b01,
    ERRO  = 2'b10
  } estado_t;

  localparam logic [1:0] MODO_CARGA = 2'b00;
  localparam logic [2:0] IDX_ULTIMA = 3'd6;

endpackage

// File: rtl/controlador_linhas_matriz_if.sv
// Mode keys, column select, pattern-write port and row-side outputs of the matrix driver.
interface controlador_linhas_matriz_if;
  import pkg_matriz::*;

  logic                   ch1;
  logic                   ch0;
  logic [NUM_COLUNAS-1:0] coluna_ativa;
  logic [2:0]             endereco;
  logic [NUM_LINHAS-1:0]  dado_coluna;
  logic                   escreve;
  logic [NUM_LINHAS-1:0]  linhas;
  logic                   erro_coluna;
  logic                   quadro_completo;

  modport master (
    output ch1, ch0, coluna_ativa, endereco, dado_coluna, escreve,
    input  linhas, erro_coluna, quadro_completo
  );

  modport slave (
    input  ch1, ch0, coluna_ativa, endereco, dado_coluna, escreve,
    output linhas, erro_coluna, quadro_completo
  );
endinterface

// File: rtl/controlador_linhas_matriz_codificador.sv
// Combinational decoder from the one-hot column register to a column index.
// Any code without exactly one bit set is reported as invalid.
module codificador_onehot_coluna
  import pkg_matriz::*;
(
  input  logic [NUM_COLUNAS-1:0] coluna_ativa_i,
  output logic [2:0]             idx_o,
  output logic                   valido_o
);

  always_comb begin
    idx_o    = 3'd0;
    valido_o = 1'b0;
    case (coluna_ativa_i)
      7'b0000001: begin idx_o = 3'd0; valido_o = 1'b1; end
      7'b0000010: begin idx_o = 3'd1; valido_o = 1'b1; end
      7'b0000100: begin idx_o = 3'd2; valido_o = 1'b1; end
      7'b0001000: begin idx_o = 3'd3; valido_o = 1'b1; end
      7'b0010000: begin idx_o = 3'd4; valido_o = 1'b1; end
      7'b0100000: begin idx_o = 3'd5; valido_o = 1'b1; end
      7'b1000000: begin idx_o = 3'd6; valido_o = 1'b1; end
      default:    begin idx_o = 3'd0; valido_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/controlador_linhas_matriz.sv
// Row driver for a 7x5 LED matrix: pattern memory, load/scan/error FSM,
// registered row outputs and a once-per-frame pulse on the 6->0 column wrap.
module controlador_linhas_matriz
  import pkg_matriz::*;
(
  input  logic                          clk,
  input  logic                          reset,
  controlador_linhas_matriz_if.slave    bus
);

  logic [NUM_LINHAS-1:0] mem_q [NUM_COLUNAS];

  estado_t               estado_q, estado_d;
  logic [NUM_LINHAS-1:0] linhas_q, linhas_d;
  logic                  erro_q, erro_d;
  logic                  quadro_q, quadro_d;
  logic [2:0]            idx_ant_q, idx_ant_d;
  logic                  idx_ant_ok_q, idx_ant_ok_d;

  logic [2:0]            idx_s;
  logic                  valido_s;
  logic                  modo_carga_s;
  logic                  escrita_s;

  codificador_onehot_coluna u_codificador (
    .coluna_ativa_i (bus.coluna_ativa),
    .idx_o          (idx_s),
    .valido_o       (valido_s)
  );

  assign modo_carga_s = ({bus.ch1, bus.ch0} == MODO_CARGA);
  assign escrita_s    = modo_carga_s && bus.escreve && (bus.endereco <= IDX_ULTIMA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_COLUNAS; i++) begin
        mem_q[i] <= 5'b00000;
      end
    end else if (escrita_s) begin
      mem_q[bus.endereco] <= bus.dado_coluna;
    end else begin
      mem_q <= mem_q;
    end
  end

  // Outputs are computed from the state being entered so rows track the column on the same edge.
  always_comb begin
    estado_d     = estado_q;
    linhas_d     = 5'b00000;
    erro_d       = 1'b0;
    quadro_d     = 1'b0;
    idx_ant_d    = idx_ant_q;
    idx_ant_ok_d = 1'b0;

    if (modo_carga_s) begin
      estado_d = CARGA;
    end else if (valido_s) begin
      estado_d = VARRE;
    end else begin
      estado_d = ERRO;
    end

    case (estado_d)
      CARGA: begin
        linhas_d = 5'b00000;
      end
      VARRE: begin
        linhas_d     = mem_q[idx_s];
        quadro_d     = (estado_q == VARRE) && idx_ant_ok_q &&
                       (idx_ant_q == IDX_ULTIMA) && (idx_s == 3'd0);
        idx_ant_d    = idx_s;
        idx_ant_ok_d = 1'b1;
      end
      ERRO: begin
        linhas_d = 5'b00000;
        erro_d   = 1'b1;
      end
      default: begin
        linhas_d = 5'b00000;
        erro_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q     <= CARGA;
      linhas_q     <= 5'b00000;
      erro_q       <= 1'b0;
      quadro_q     <= 1'b0;
      idx_ant_q    <= 3'd0;
      idx_ant_ok_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      linhas_q     <= linhas_d;
      erro_q       <= erro_d;
      quadro_q     <= quadro_d;
      idx_ant_q    <= idx_ant_d;
      idx_ant_ok_q <= idx_ant_ok_d;
    end
  end

  assign bus.linhas          = linhas_q;
  assign bus.erro_coluna     = erro_q;
  assign bus.quadro_completo = quadro_q;

endmodule

// File: tb/tb_controlador_linhas_matriz.sv
// Directed bench for the LED matrix row driver with hand-computed expectations.
module tb_controlador_linhas_matriz;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  controlador_linhas_matriz_if bus ();

  controlador_linhas_matriz dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] lin, input logic err, input logic qd);
    check({tag, ".linhas"}, bus.linhas, lin);
    check({tag, ".erro"}, {4'b0000, bus.erro_coluna}, {4'b0000, err});
    check({tag, ".quadro"}, {4'b0000, bus.quadro_completo}, {4'b0000, qd});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset            = 1'b1;
    bus.ch1          = 1'b0;
    bus.ch0          = 1'b0;
    bus.coluna_ativa = 7'b0000000;
    bus.endereco     = 3'd0;
    bus.dado_coluna  = 5'b00000;
    bus.escreve      = 1'b0;
    #3;
    check_all("reset", 5'b00000, 1'b0, 1'b0);
    tick();
    reset = 1'b0;

    // Load mode: one legal write and one to the ignored address 7
    bus.escreve = 1'b1; bus.endereco = 3'd3; bus.dado_coluna = 5'b10101;
    tick();
    check_all("load_w3", 5'b00000, 1'b0, 1'b0);
    bus.endereco = 3'd7; bus.dado_coluna = 5'b11111;
    tick();
    check_all("load_w7", 5'b00000, 1'b0, 1'b0);
    bus.escreve = 1'b0;

    bus.ch0 = 1'b1; bus.coluna_ativa = 7'b0001000;
    tick();
    check_all("show_w3", 5'b10101, 1'b0, 1'b0);
    bus.coluna_ativa = 7'b1000000;
    tick();
    check_all("w7_ignored", 5'b00000, 1'b0, 1'b0);
    bus.ch0 = 1'b0;
    tick();
    check_all("back_to_carga", 5'b00000, 1'b0, 1'b0);

    // Load words 0..6 with 1..7
    bus.escreve = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.endereco    = 3'(i);
      bus.dado_coluna = 5'(i + 1);
      tick();
      check_all("load_seq", 5'b00000, 1'b0, 1'b0);
    end
    bus.escreve = 1'b0;

    // Full scan; no pulse until the wrap back to column 0
    bus.ch0 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.coluna_ativa = 7'b0000001 << i;
      tick();
      check_all("scan", 5'(i + 1), 1'b0, 1'b0);
    end
    bus.coluna_ativa = 7'b0000001;
    tick();
    check_all("wrap", 5'b00001, 1'b0, 1'b1);
    bus.coluna_ativa = 7'b0000010;
    tick();
    check_all("after_wrap", 5'b00010, 1'b0, 1'b0);

    // Illegal codes, then recovery without a frame pulse
    bus.ch1 = 1'b1; bus.ch0 = 1'b0; bus.coluna_ativa = 7'b0000011;
    tick();
    check_all("erro_two_hot", 5'b00000, 1'b1, 1'b0);
    bus.coluna_ativa = 7'b0000000;
    tick();
    check_all("erro_zero", 5'b00000, 1'b1, 1'b0);
    bus.coluna_ativa = 7'b0000100;
    tick();
    check_all("recover", 5'b00011, 1'b0, 1'b0);

    // Write attempt during scan must not alter word 2
    bus.escreve = 1'b1; bus.endereco = 3'd2; bus.dado_coluna = 5'b11111;
    bus.coluna_ativa = 7'b1000000;
    tick();
    check_all("scan_write", 5'b00111, 1'b0, 1'b0);
    bus.escreve = 1'b0;
    bus.coluna_ativa = 7'b0000100;
    tick();
    check_all("word2_kept", 5'b00011, 1'b0, 1'b0);

    // ERRO with keys back to 00 goes to CARGA
    bus.coluna_ativa = 7'b0000000;
    tick();
    check_all("erro_again", 5'b00000, 1'b1, 1'b0);
    bus.ch1 = 1'b0;
    tick();
    check_all("erro_to_carga", 5'b00000, 1'b0, 1'b0);

    // Reset mid-scan while the frame pulse is high
    bus.ch0 = 1'b1; bus.coluna_ativa = 7'b1000000;
    tick();
    check_all("pre_reset_c6", 5'b00111, 1'b0, 1'b0);
    bus.coluna_ativa = 7'b0000001;
    tick();
    check_all("pre_reset_wrap", 5'b00001, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 5'b00000, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    bus.coluna_ativa = 7'b0000001;
    tick();
    check_all("post_reset", 5'b00000, 1'b0, 1'b0);
    bus.coluna_ativa = 7'b0001000;
    tick();
    check_all("post_reset_mem", 5'b00000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
